// File: rtl/cnn_conv1_pkg.sv
// -----------------------------------------------------------------------------
// cnn_conv1_pkg
// Shared types, default geometry and sizing helpers for the conv1 window
// feeder and its window store.
//   state_t       : feeder FSM state (IDLE, RUN)
//   DEF_*         : default geometry (640x480 image, 3x3 kernel, 1-pixel ring)
//   DEF_WP/DEF_HP : default padded frame width / height
//   padded_dim()  : unpadded dimension plus the zero ring on both sides
//   window_count(): number of window positions along one padded dimension
//   cnt_width()   : width of the padded-position counters
// -----------------------------------------------------------------------------
package cnn_conv1_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_INPUT_WIDTH  = 640;
    localparam int DEF_INPUT_HEIGHT = 480;
    localparam int DEF_KERNEL_SIZE  = 3;
    localparam int DEF_PADDING      = 1;

    localparam int DEF_WP = DEF_INPUT_WIDTH + 2 * DEF_PADDING;
    localparam int DEF_HP = DEF_INPUT_HEIGHT + 2 * DEF_PADDING;

    function automatic int padded_dim(input int dim, input int pad);
        return dim + 2 * pad;
    endfunction

    // Window positions along one padded dimension for a given stride.
    function automatic int window_count(input int padded, input int k, input int stride);
        return (padded - k) / stride + 1;
    endfunction

    // Counters must hold 0..max(Wp,Hp)-1.
    function automatic int cnt_width(input int wp, input int hp);
        int m;
        m = (wp > hp) ? wp : hp;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cnn_buffer_conv1.sv
// -----------------------------------------------------------------------------
// cnn_buffer_conv1
// Sliding-window store for the conv1 feeder. Every padded position of the
// frame is shifted in, in raster order, so the pixel pushed d pushes ago sits
// at offset d. Tap l*LINE_WIDTH+k therefore holds padded pixel (r-l, c-k)
// relative to the most recent push at (r, c), valid whenever c >= K-1.
//   clk      : clock
//   rst      : synchronous active-high reset, clears the store
//   en       : shift one pixel in
//   data_in  : pixel (or zero for padding) to shift in
//   data_out : KxK window, slice (l*K+k)*DATA_WIDTH = pixel (r-l, c-k)
// -----------------------------------------------------------------------------
module cnn_buffer_conv1
    import cnn_conv1_pkg::*;
#(
    parameter int pDATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int pLINE_WIDTH  = DEF_WP,
    parameter int pKERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [pDATA_WIDTH-1:0]                        data_in,
    output logic [pDATA_WIDTH*pKERNEL_SIZE*pKERNEL_SIZE-1:0] data_out
);

    localparam int DEPTH = (pKERNEL_SIZE - 1) * pLINE_WIDTH + pKERNEL_SIZE;

    logic [pDATA_WIDTH-1:0] sr [DEPTH];

    // NOTE: the store is reset explicitly so that stale contents are
    // deterministic after reset; this costs a reset net on every stage, which
    // is acceptable for a flop-based shift line but would not map to RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else if (en) begin
            sr[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    for (genvar l = 0; l < pKERNEL_SIZE; l++) begin : g_row
        for (genvar k = 0; k < pKERNEL_SIZE; k++) begin : g_col
            assign data_out[(l*pKERNEL_SIZE+k)*pDATA_WIDTH +: pDATA_WIDTH] =
                sr[l*pLINE_WIDTH + k];
        end
    end

endmodule

// File: rtl/cnn_window_feeder_conv1.sv
// -----------------------------------------------------------------------------
// cnn_window_feeder_conv1
// Front end for conv1: walks the zero-padded frame in raster order, pushing
// zeros at ring positions and stream pixels at interior positions into the
// window store, and emits every complete KxK window with coordinate tags.
//   clk, rst   : clock, synchronous active-high reset
//   s_valid/s_ready/s_data : raster pixel stream in
//   m_valid/m_ready/m_data : KxK window out, held stable while stalled
//   m_last     : final window of the frame (qualified by m_valid)
//   m_row/m_col: window coordinates, top-left origin
//   frame_done : one-cycle pulse after the last padded position is pushed
// Build option: CNN_WIN_STRIDE2_EN emits only windows at even offsets and
// reports halved coordinates.
// -----------------------------------------------------------------------------
module cnn_window_feeder_conv1
    import cnn_conv1_pkg::*;
#(
    parameter int pDATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int pINPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int pINPUT_HEIGHT = DEF_INPUT_HEIGHT,
    parameter int pKERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int pPADDING      = DEF_PADDING
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             s_valid,
    output logic                                             s_ready,
    input  logic [pDATA_WIDTH-1:0]                           s_data,
    output logic                                             m_valid,
    input  logic                                             m_ready,
    output logic [pDATA_WIDTH*pKERNEL_SIZE*pKERNEL_SIZE-1:0] m_data,
    output logic                                             m_last,
    output logic [15:0]                                      m_row,
    output logic [15:0]                                      m_col,
    output logic                                             frame_done
);

    localparam int WP = padded_dim(pINPUT_WIDTH, pPADDING);
    localparam int HP = padded_dim(pINPUT_HEIGHT, pPADDING);
    localparam int CW = cnt_width(WP, HP);

    localparam logic [CW-1:0] PR_LAST  = CW'(HP - 1);
    localparam logic [CW-1:0] PC_LAST  = CW'(WP - 1);
    localparam logic [CW-1:0] PAD_LO   = CW'(pPADDING);
    localparam logic [CW-1:0] ROW_END  = CW'(pINPUT_HEIGHT + pPADDING);
    localparam logic [CW-1:0] COL_END  = CW'(pINPUT_WIDTH + pPADDING);
    localparam logic [CW-1:0] WIN_BASE = CW'(pKERNEL_SIZE - 1);

`ifdef CNN_WIN_STRIDE2_EN
    // Largest even window offsets: the strided frame ends there.
    localparam logic [CW-1:0] ROW_OFF_LAST = CW'((window_count(HP, pKERNEL_SIZE, 2) - 1) * 2);
    localparam logic [CW-1:0] COL_OFF_LAST = CW'((window_count(WP, pKERNEL_SIZE, 2) - 1) * 2);
`endif

    state_t                 state, state_next;
    logic [CW-1:0]          pr, pc;
    logic                   padding, adv, push, last_pos;
    logic                   emit_pos, last_win;
    logic [CW-1:0]          row_off, col_off;
    logic [15:0]            row_tag, col_tag;
    logic [pDATA_WIDTH-1:0] buf_in;

    // Position decode and window tagging.
    always_comb begin
        padding  = (pr < PAD_LO) || (pr >= ROW_END) || (pc < PAD_LO) || (pc >= COL_END);
        adv      = !m_valid || m_ready;
        last_pos = (pr == PR_LAST) && (pc == PC_LAST);
        row_off  = pr - WIN_BASE;
        col_off  = pc - WIN_BASE;
        buf_in   = padding ? '0 : s_data;
`ifdef CNN_WIN_STRIDE2_EN
        emit_pos = (pr >= WIN_BASE) && (pc >= WIN_BASE) && !row_off[0] && !col_off[0];
        last_win = (row_off == ROW_OFF_LAST) && (col_off == COL_OFF_LAST);
        row_tag  = 16'(row_off >> 1);
        col_tag  = 16'(col_off >> 1);
`else
        emit_pos = (pr >= WIN_BASE) && (pc >= WIN_BASE);
        last_win = last_pos;
        row_tag  = 16'(row_off);
        col_tag  = 16'(col_off);
`endif
    end

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                s_ready = !padding && adv;
                push    = adv && (padding || s_valid);
                if (push && last_pos) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr         <= '0;
            pc         <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_row      <= '0;
            m_col      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= push && last_pos;
            if (push) begin
                if (pc == PC_LAST) begin
                    pc <= '0;
                    pr <= (pr == PR_LAST) ? '0 : pr + CW'(1);
                end else begin
                    pc <= pc + CW'(1);
                end
            end
            // A new emitting push reloads the tags; otherwise a handshake
            // retires the current window. Stalled windows keep their tags.
            if (push && emit_pos) begin
                m_valid <= 1'b1;
                m_last  <= last_win;
                m_row   <= row_tag;
                m_col   <= col_tag;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    cnn_buffer_conv1 #(
        .pDATA_WIDTH  (pDATA_WIDTH),
        .pLINE_WIDTH  (WP),
        .pKERNEL_SIZE (pKERNEL_SIZE)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .en       (push),
        .data_in  (buf_in),
        .data_out (m_data)
    );

endmodule

// File: doc/cnn_window_feeder_conv1.md
# cnn_window_feeder_conv1

Stream-side front end for the conv1 layer. Accepts a raster-order pixel stream over a valid/ready handshake and inserts the zero padding ring. It drives an internal sliding-window line buffer and presents each complete KxK receptive field downstream with valid/ready, last-window and coordinate tags. Sits between the input DMA/stream and the conv1 MAC array.

## Interface
- pDATA_WIDTH, 8, pixel width in bits
- pINPUT_WIDTH, 640, unpadded image width W
- pINPUT_HEIGHT, 480, unpadded image height H
- pKERNEL_SIZE, 3, window size K
- pPADDING, 1, zero ring width P
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid&&s_ready
- s_data  in  pDATA_WIDTH  pixel, raster order, row-major
- m_valid  out  1  window valid
- m_ready  in  1  downstream accepts window
- m_data  out  pDATA_WIDTH*K*K  window; slice (l*K+k)*pDATA_WIDTH +: pDATA_WIDTH = padded pixel (r-l, c-k)
- m_last  out  1  final window of frame, qualified by m_valid
- m_row, m_col  out  16 each  output-window coordinates (top-left origin)
- frame_done  out  1  one-cycle pulse after last padded position pushed

## Operation
- Padded frame: Wp=W+2P columns, Hp=H+2P rows; counters pr (0..Hp-1), pc (0..Wp-1), width $clog2(max(Wp,Hp)).
- Position is padding if pr<P, pr>=H+P, pc<P or pc>=W+P; otherwise interior.
- States: IDLE, RUN. IDLE->RUN on s_valid=1 (no pixel consumed in IDLE). RUN->IDLE on push of (Hp-1, Wp-1).
- adv = !m_valid || m_ready.
- push = RUN && adv && (padding || s_valid). Padding pushes zero without consuming input; interior pushes s_data.
- s_ready = RUN && interior && adv (combinational).
- On push, the buffer is enabled for one cycle, and pc increments (wraps to 0 at Wp-1, then pr increments). At (Hp-1, Wp-1), both wrap to 0.
- Window emission: a push at (pr,pc) with pr>=K-1 and pc>=K-1 sets m_valid next cycle, with m_row=pr-(K-1), m_col=pc-(K-1). m_last=1 when pr=Hp-1 and pc=Wp-1.
- m_valid clears on m_ready unless a new emitting push occurs in the same cycle.
- While m_valid && !m_ready: no push, buffer enable low, m_data/m_row/m_col/m_last held stable.
- Output windows per frame: (Wp-K+1)*(Hp-K+1).
- Back-to-back frames: the next frame may start while the last window is still pending. IDLE->RUN is allowed, but pushes wait on adv. Stale buffer rows are never emitted because r<K-1 windows are suppressed.

## Timing
- Reset values: s_ready 0, m_valid 0, m_last 0, m_row 0, m_col 0, frame_done 0, state IDLE, counters 0, buffer cleared.
- Latency: m_valid/m_data appear 1 cycle after the push completing the window.
- Throughput: 1 push/cycle with m_ready=1 and s_valid=1. Minimum frame time is Wp*Hp+1 cycles from s_valid.
- frame_done: asserted the cycle after the final push, coincident with the m_valid that carries m_last.
- Input stall (s_valid=0 at an interior position): no push, counters hold. Padding positions never stall on s_valid.
- Reset mid-frame: partial frame discarded, no frame_done, all outputs return to reset values next cycle.

## Configuration
- CNN_WIN_STRIDE2_EN defined: emit only windows with even (pr-(K-1)) and even (pc-(K-1)). m_row/m_col equal those offsets divided by 2. m_last is on the final strided window, i.e. the last even offsets. Non-emitting pushes never block on m_ready beyond adv.
- Undefined: stride 1, every window emitted as above.

## Structure
- Package cnn_conv1_pkg: state enum (IDLE, RUN), localparams Wp, Hp, output counts, counter width function.
- Sub-module: cnn_buffer_conv1 instance as the window store; its en is driven by push and its data_in is the pixel or zero. Its data_out maps directly to m_data.

## Test plan
- W=4,H=3,K=3,P=1, pixels 1..12, m_ready=1 -> 12 windows. First window: m_row=0, m_col=0, l=0 slice {6,5,0}, l=1 {2,1,0}, l=2 {0,0,0}. m_last on the 12th window together with frame_done.
- Same frame, s_valid toggled 1/0 every cycle -> identical window sequence; s_ready never high at padding positions.
- m_ready held low for 5 cycles on window 3 -> m_data/m_row/m_col stable, s_ready=0, no window lost or duplicated.
- rst asserted after 7 pushes -> all outputs 0 next cycle; a following full frame produces the correct 12 windows and no spurious frame_done.
- Two frames back-to-back with m_ready=1 -> 24 windows, frame_done pulses exactly twice, second frame's first window free of first-frame data.
- CNN_WIN_STRIDE2_EN with W=4,H=3 -> 4 windows at (0,0),(0,1),(1,0),(1,1); m_last on the fourth.
